// File: rtl/user_ram_bridge_if.sv
// user_ram_bridge_if
//   Bundles the CPU native memory port and the user_ram initiator port that
//   meet at user_ram_bridge.
//   slave  : bridge view. It takes CPU requests and RAM read data, and drives
//            the CPU response and the RAM control, address and data.
//   master : environment view (CPU plus RAM). It is the mirror of slave.
//   Signals:
//     mem_valid_i / mem_addr_i / mem_wdata_i / mem_wstrb_i  CPU request (wstrb==0 means read)
//     mem_ready_o / mem_rdata_o                             CPU completion pulse and read data
//     ram_wr_en_o / ram_rd_en_o / ram_addr_o / ram_di_o     user_ram control, address and write data
//     ram_do_i                                              user_ram registered read data
interface user_ram_bridge_if #(
    parameter int ADDR_BIT = 8
);
    logic                mem_valid_i;
    logic [31:0]         mem_addr_i;
    logic [31:0]         mem_wdata_i;
    logic [3:0]          mem_wstrb_i;
    logic                mem_ready_o;
    logic [31:0]         mem_rdata_o;
    logic                ram_wr_en_o;
    logic                ram_rd_en_o;
    logic [ADDR_BIT-1:0] ram_addr_o;
    logic [31:0]         ram_di_o;
    logic [31:0]         ram_do_i;

    modport slave (
        input  mem_valid_i, mem_addr_i, mem_wdata_i, mem_wstrb_i, ram_do_i,
        output mem_ready_o, mem_rdata_o, ram_wr_en_o, ram_rd_en_o, ram_addr_o, ram_di_o
    );

    modport master (
        output mem_valid_i, mem_addr_i, mem_wdata_i, mem_wstrb_i, ram_do_i,
        input  mem_ready_o, mem_rdata_o, ram_wr_en_o, ram_rd_en_o, ram_addr_o, ram_di_o
    );
endinterface

// File: rtl/user_ram_bridge.sv
// user_ram_bridge
//   Initiator side of a user_ram port. It turns CPU valid/ready requests with
//   byte strobes into user_ram wr_en/rd_en/addr/di cycles. user_ram only
//   takes full-word writes, so a partial-word store runs as read-modify-write.
//   Ports:
//     clk_i  single clock; all logic runs on the rising edge
//     rst_i  asynchronous, active-high reset
//     bus    user_ram_bridge_if.slave (CPU request/response and RAM control)
//   Every output comes straight from a flop.
//   Latency, counted from the IDLE cycle that samples a hit to mem_ready_o:
//     read 3, full write 2, partial write 4.
module user_ram_bridge #(
    parameter int          ADDR_BIT  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    user_ram_bridge_if.slave  bus
);
    localparam int HI = ADDR_BIT + 2;

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR, DONE} state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_BIT-1:0] addr_q, addr_d;
    logic [31:0]         di_q, di_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rmw_q, rmw_d;
    logic [3:0]          strb_q, strb_d;

    logic                hit;
    logic [31:0]         merged;
    logic                unused_addr_bits;

    // Byte-offset bits play no part because the RAM is word-addressed.
    assign unused_addr_bits = ^bus.mem_addr_i[1:0];

    assign hit = bus.mem_valid_i && (bus.mem_addr_i[31:HI] == BASE_ADDR[31:HI]);

    // During RMW, di_q holds the CPU write data that was latched on IDLE exit.
    // Strobed bytes come from it and the rest come from the word just read.
    always_comb begin
        merged = '0;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = strb_q[k] ? di_q[8*k +: 8] : bus.ram_do_i[8*k +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        di_d    = di_q;
        rdata_d = rdata_q;
        rmw_d   = rmw_q;
        strb_d  = strb_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    addr_d = bus.mem_addr_i[HI-1:2];
                    if (bus.mem_wstrb_i == 4'hF) begin
                        state_d = WR;
                        wr_en_d = 1'b1;
                        di_d    = bus.mem_wdata_i;
                    end else begin
                        // A read or a partial store: both begin with a RAM read.
                        state_d = RD0;
                        rd_en_d = 1'b1;
                        rmw_d   = (bus.mem_wstrb_i != 4'h0);
                        strb_d  = bus.mem_wstrb_i;
                        if (bus.mem_wstrb_i != 4'h0) di_d = bus.mem_wdata_i;
                    end
                end
            end
            RD0: begin
                state_d = RD1;
                rd_en_d = 1'b1;
            end
            RD1: begin
                // user_ram presents the word read in RD0 during this cycle.
                if (rmw_q) begin
                    state_d = WR;
                    wr_en_d = 1'b1;
                    di_d    = merged;
                end else begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    rdata_d = bus.ram_do_i;
                end
            end
            WR: begin
                state_d = DONE;
                ready_d = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            di_q    <= '0;
            rdata_q <= '0;
            rmw_q   <= 1'b0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            rdata_q <= rdata_d;
            rmw_q   <= rmw_d;
            strb_q  <= strb_d;
        end
    end

    assign bus.mem_ready_o = ready_q;
    assign bus.mem_rdata_o = rdata_q;
    assign bus.ram_rd_en_o = rd_en_q;
    assign bus.ram_wr_en_o = wr_en_q;
    assign bus.ram_addr_o  = addr_q;
    assign bus.ram_di_o    = di_q;
endmodule

// File: tb/tb_user_ram_bridge.sv
// Bench for user_ram_bridge. A behavioural user_ram is attached to the bridge.
// The driver pushes one expected transaction per request into a queue. A
// monitor samples on the falling edge and checks the RAM cycles and the
// ready/rdata response against the head of that queue.
module tb_user_ram_bridge;
    localparam logic [31:0] BASE = 32'h0002_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    user_ram_bridge_if #(.ADDR_BIT(8)) bus();

    user_ram_bridge #(.ADDR_BIT(8), .BASE_ADDR(BASE)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Behavioural user_ram: synchronous write, registered read.
    logic [31:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        bus.ram_do_i = 32'h0;
    end
    always @(posedge clk) begin
        if (bus.ram_wr_en_o) ram[bus.ram_addr_o] <= bus.ram_di_o;
        if (bus.ram_rd_en_o) bus.ram_do_i <= ram[bus.ram_addr_o];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // kind: 0 = read, 1 = full write, 2 = partial write
    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] di;
        logic [31:0] rdata;
        int          rcyc;
    } exp_t;
    exp_t q[$];
    int done_cnt = 0;
    int expect_done = 0;

    // Monitor
    int rd_cnt = 0;
    int wr_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            rd_cnt = 0;
            wr_cnt = 0;
        end else if (q.size() == 0) begin
            if (bus.ram_rd_en_o || bus.ram_wr_en_o || bus.mem_ready_o)
                check("unexpected_activity",
                      {29'h0, bus.ram_rd_en_o, bus.ram_wr_en_o, bus.mem_ready_o}, 32'h0);
        end else begin
            exp_t e;
            e = q[0];
            if (bus.ram_rd_en_o || bus.ram_wr_en_o) begin
                check("rd_wr_exclusive", {31'h0, bus.ram_rd_en_o & bus.ram_wr_en_o}, 32'h0);
                check("ram_addr", 32'(bus.ram_addr_o), 32'(e.addr));
            end
            if (bus.ram_rd_en_o) rd_cnt++;
            if (bus.ram_wr_en_o) begin
                wr_cnt++;
                check("ram_di", bus.ram_di_o, e.di);
            end
            if (bus.mem_ready_o) begin
                check("ready_cycle", 32'(cyc), 32'(e.rcyc));
                check("rd_en_cycles", 32'(rd_cnt), (e.kind == 1) ? 32'd0 : 32'd2);
                check("wr_en_cycles", 32'(wr_cnt), (e.kind == 0) ? 32'd0 : 32'd1);
                if (e.kind == 0) check("rdata", bus.mem_rdata_o, e.rdata);
                void'(q.pop_front());
                rd_cnt = 0;
                wr_cnt = 0;
                done_cnt++;
            end
        end
    end

    // Drive a request from just after a falling edge. b2b=1 means the bridge
    // is in DONE now, so its IDLE sampling cycle is the next one.
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp_di, input logic [31:0] exp_rdata, input bit b2b);
        exp_t e;
        e.kind  = (wstrb == 4'h0) ? 0 : (wstrb == 4'hF) ? 1 : 2;
        e.addr  = addr[9:2];
        e.di    = exp_di;
        e.rdata = exp_rdata;
        e.rcyc  = cyc + int'(b2b) + ((e.kind == 0) ? 3 : (e.kind == 1) ? 2 : 4);
        q.push_back(e);
        expect_done++;
        bus.mem_valid_i = 1'b1;
        bus.mem_addr_i  = addr;
        bus.mem_wdata_i = wdata;
        bus.mem_wstrb_i = wstrb;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt != expect_done && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt != expect_done) begin
            check("ready_timeout", 32'(done_cnt), 32'(expect_done));
            expect_done = done_cnt;
        end
    endtask

    task automatic idle_bus();
        bus.mem_valid_i = 1'b0;
        bus.mem_addr_i  = 32'h0;
        bus.mem_wdata_i = 32'h0;
        bus.mem_wstrb_i = 4'h0;
    endtask

    initial begin
        idle_bus();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              {28'h0, bus.mem_ready_o, bus.ram_wr_en_o, bus.ram_rd_en_o, 1'b0}, 32'h0);
        check("reset_addr_di", {24'h0, bus.ram_addr_o} | bus.ram_di_o, 32'h0);
        check("reset_rdata", bus.mem_rdata_o, 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;

        // 1: full write
        issue(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        wait_done(); idle_bus();
        @(negedge clk); #1;
        check("ram4_after_full", ram[4], 32'hDEAD_BEEF);

        // 2: read back
        issue(BASE + 32'h10, 32'h0, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        wait_done(); idle_bus();
        @(negedge clk); #1;

        // 3: partial write to byte 1
        issue(BASE + 32'h10, 32'h0000_5A00, 4'b0010, 32'hDEAD_5AEF, 32'h0, 1'b0);
        wait_done(); idle_bus();
        @(negedge clk); #1;
        check("ram4_after_rmw", ram[4], 32'hDEAD_5AEF);
        check("rdata_held_after_write", bus.mem_rdata_o, 32'hDEAD_BEEF);

        // 4: miss below the window, held for 10 cycles
        begin
            int act;
            act = 0;
            bus.mem_valid_i = 1'b1;
            bus.mem_addr_i  = BASE - 32'h4;
            bus.mem_wdata_i = 32'hFFFF_FFFF;
            bus.mem_wstrb_i = 4'hF;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk); #1;
                act += int'(bus.ram_rd_en_o) + int'(bus.ram_wr_en_o) + int'(bus.mem_ready_o);
            end
            check("miss_activity", 32'(act), 32'h0);
            idle_bus();
        end
        @(negedge clk); #1;

        // 5: reset pulse during RD1 of a partial write
        issue(BASE + 32'h10, 32'h0000_0011, 4'b0001, 32'hDEAD_5A11, 32'h0, 1'b0);
        @(negedge clk);            // RD0
        @(negedge clk);            // RD1
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs",
              {28'h0, bus.mem_ready_o, bus.ram_wr_en_o, bus.ram_rd_en_o, 1'b0}, 32'h0);
        check("midrst_addr_di_rdata", {24'h0, bus.ram_addr_o} | bus.ram_di_o | bus.mem_rdata_o, 32'h0);
        idle_bus();
        @(negedge clk);
        #2 rst = 1'b0;
        expect_done = done_cnt;
        @(negedge clk); #1;
        check("ram4_after_abort", ram[4], 32'hDEAD_5AEF);
        issue(BASE + 32'h10, 32'h0, 4'h0, 32'h0, 32'hDEAD_5AEF, 1'b0);
        wait_done(); idle_bus();
        @(negedge clk); #1;

        // 6: back-to-back write(F) word 0 / read word 0 / write(1) word 1
        issue(BASE + 32'h0, 32'h1234_5678, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        wait_done();
        issue(BASE + 32'h0, 32'h0, 4'h0, 32'h0, 32'h1234_5678, 1'b1);
        wait_done();
        issue(BASE + 32'h4, 32'h0000_00AB, 4'b0001, 32'h0000_00AB, 32'h0, 1'b1);
        wait_done(); idle_bus();
        @(negedge clk); #1;
        check("ram0_final", ram[0], 32'h1234_5678);
        check("ram1_final", ram[1], 32'h0000_00AB);
        check("rdata_final_held", bus.mem_rdata_o, 32'h1234_5678);
        check("queue_drained", 32'(q.size()), 32'h0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
